tc_result_collector: RTL
========================

TC_RESULT_COLLECTOR -- requirements
Module: tc_result_collector

Interface
REQ-001 Parameter NUM_ELEM, default 4, number of dot-product results packed per writeback vector; SHALL be a power of 2, at least 2.
REQ-002 Parameter EXPWIDTH, default 8, exponent width of each result.
REQ-003 Parameter PRECISION, default 24, significand width of each result; W = EXPWIDTH+PRECISION.
REQ-004 The module SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid_i  in  1  result element valid, from the tensor dot-product stage.
REQ-008 in_ready_o  out  1  element accepted when in_valid_i&in_ready_o.
REQ-009 result_i  in  W  FP result element.
REQ-010 fflags_i  in  5  element exception flags.
REQ-011 ctrl_reg_idxw_i  in  8  destination register index.
REQ-012 ctrl_warpid_i  in  `DEPTH_WARP  warp id.
REQ-013 out_valid_o  out  1  packed vector valid.
REQ-014 out_ready_i  in  1  writeback arbiter ready.
REQ-015 wb_data_o  out  NUM_ELEM*W  packed vector; element k at bits [(k+1)*W-1 -: W].
REQ-016 wb_fflags_o  out  5  bitwise OR of all element fflags.
REQ-017 wb_reg_idxw_o  out  8  element-0 register index.
REQ-018 wb_warpid_o  out  `DEPTH_WARP  element-0 warp id.
REQ-019 err_o  out  1  one-cycle pulse on tag mismatch.

Function
REQ-020 Elements SHALL be packed in arrival order; an element counter cnt (log2(NUM_ELEM) bits) SHALL select slot cnt of an assembly register.
REQ-021 For cnt < NUM_ELEM-1, in_ready_o SHALL be 1 unconditionally.
REQ-022 For cnt = NUM_ELEM-1, in_ready_o SHALL be 1 only when the output register is empty or out_valid_o&out_ready_i in the same cycle.
REQ-023 On acceptance of the last element, the assembly register plus that element SHALL transfer to the output register; out_valid_o SHALL assert the next cycle. Latency: 1 cycle.
REQ-024 cnt SHALL wrap from NUM_ELEM-1 to 0 on last-element acceptance; collection of the next vector SHALL continue while the output is held.
REQ-025 wb_fflags_o SHALL be the OR of the fflags of all NUM_ELEM elements of that vector only.
REQ-026 Tags SHALL be latched from element 0; if a later element's ctrl_reg_idxw_i or ctrl_warpid_i differs, err_o SHALL pulse in the cycle after acceptance; the element is still stored.
REQ-027 Simultaneous output drain and last-element acceptance SHALL reload the output register with out_valid_o remaining 1, with no bubble.
REQ-028 out_valid_o SHALL deassert the cycle after a fire with no reload.
REQ-029 Output payload SHALL stay stable while out_valid_o&!out_ready_i.

Reset
REQ-030 On rst: cnt=0, out_valid_o=0, err_o=0, wb_data_o=0, wb_fflags_o=0, wb_reg_idxw_o=0, wb_warpid_o=0, accumulated fflags=0.
REQ-031 Reset mid-vector SHALL discard partial elements; the first element accepted after reset is element 0.
REQ-032 in_ready_o SHALL be 1 during and after reset, since cnt=0.

Structure
REQ-033 `DEPTH_WARP SHALL come from the shared define file; the default NUM_ELEM value SHALL be a shared constant there.
REQ-034 The output register with its valid/ready logic SHALL be one sub-module, tc_wb_slot; the rest stays flat.

Verification
REQ-035 NUM_ELEM=4: send 1.0,2.0,3.0,4.0 (0x3F800000,0x40000000,0x40400000,0x40800000) back-to-back with out_ready_i=1 -> out_valid_o one cycle after the 4th, wb_data_o={0x40800000,0x40400000,0x40000000,0x3F800000}.
REQ-036 Hold out_ready_i=0, stream 8 elements -> the 4th is accepted, the 5th–7th are accepted, the 8th is held with in_ready_o=0 until out_ready_i=1, and the 8th is accepted in the same cycle as the drain.
REQ-037 fflags 0x01,0x00,0x04,0x00 -> wb_fflags_o=0x05; the next vector, all 0x00 -> wb_fflags_o=0x00.
REQ-038 Element 2 with warpid differing from element 0 -> err_o pulses once; wb_warpid_o equals element-0 warpid.
REQ-039 rst after 2 elements, then 4 fresh elements -> the vector contains only the fresh elements.
REQ-040 Random valid/ready stalls over 1000 vectors -> scoreboard order and data match, and no element is lost or duplicated.

Source files
------------

// File: rtl/tc_result_collector_pkg.sv
// ============================================================================
// Module   : tc_result_collector_pkg
// Purpose  : Shared defines, constants and types for the tensor-core result
//            collector and its writeback slot.
//            DEPTH_WARP          - warp id width, shared across the core
//            TC_NUM_ELEM_DEFAULT - default number of results per vector
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

`ifndef TC_NUM_ELEM_DEFAULT
`define TC_NUM_ELEM_DEFAULT 4
`endif

package tc_result_collector_pkg;

   localparam int unsigned C_NUM_ELEM_DEFAULT = `TC_NUM_ELEM_DEFAULT;
   localparam int unsigned C_FFLAGS_W         = 5;
   localparam int unsigned C_REG_IDX_W        = 8;
   localparam int unsigned C_WARP_W           = `DEPTH_WARP;

   // Destination tag carried by every element; element 0 defines the vector.
   typedef struct packed {
      logic [C_REG_IDX_W-1:0] reg_idxw;
      logic [C_WARP_W-1:0]    warpid;
   } tc_tag_t;

endpackage

`default_nettype wire

// File: rtl/tc_wb_slot.sv
// ============================================================================
// Module   : tc_wb_slot
// Purpose  : Single-entry output register with valid/ready handshake for the
//            packed writeback vector. A load may coincide with a drain, in
//            which case the register is refilled without a bubble.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            load_i            - capture the incoming vector (only when
//                                can_load_o is high)
//            data_i/fflags_i/reg_idxw_i/warpid_i - incoming payload
//            can_load_o        - register empty or draining this cycle
//            out_valid_o/out_ready_i - writeback handshake
//            data_o/fflags_o/reg_idxw_o/warpid_o - held payload
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_wb_slot
   import tc_result_collector_pkg::*;
#(
   parameter int unsigned DATA_W = 128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_i,
   input  logic [DATA_W-1:0]      data_i,
   input  logic [C_FFLAGS_W-1:0]  fflags_i,
   input  logic [C_REG_IDX_W-1:0] reg_idxw_i,
   input  logic [C_WARP_W-1:0]    warpid_i,
   output logic                   can_load_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [DATA_W-1:0]      data_o,
   output logic [C_FFLAGS_W-1:0]  fflags_o,
   output logic [C_REG_IDX_W-1:0] reg_idxw_o,
   output logic [C_WARP_W-1:0]    warpid_o
);

   logic                   r_valid;
   logic [DATA_W-1:0]      r_data;
   logic [C_FFLAGS_W-1:0]  r_fflags;
   logic [C_REG_IDX_W-1:0] r_reg_idxw;
   logic [C_WARP_W-1:0]    r_warpid;
   logic                   w_fire;

   assign w_fire     = r_valid & out_ready_i;
   assign can_load_o = ~r_valid | out_ready_i;

   // Payload only changes on load, so it stays stable while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_fflags   <= '0;
         r_reg_idxw <= '0;
         r_warpid   <= '0;
      end else begin
         if (load_i) begin
            r_valid    <= 1'b1;
            r_data     <= data_i;
            r_fflags   <= fflags_i;
            r_reg_idxw <= reg_idxw_i;
            r_warpid   <= warpid_i;
         end else if (w_fire) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid_o = r_valid;
   assign data_o      = r_data;
   assign fflags_o    = r_fflags;
   assign reg_idxw_o  = r_reg_idxw;
   assign warpid_o    = r_warpid;

endmodule

`default_nettype wire

// File: rtl/tc_result_collector.sv
// ============================================================================
// Module   : tc_result_collector
// Purpose  : Packs NUM_ELEM floating-point dot-product results, arriving one
//            at a time, into a single writeback vector. Elements fill slots
//            in arrival order; the last element bypasses the assembly
//            register straight into the output slot. Flags of the vector are
//            OR-reduced and the destination tag is taken from element 0; a
//            later element with a different tag raises a one-cycle err_o.
//            NUM_ELEM must be a power of two, at least 2.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            in_valid_i/in_ready_o     - element handshake
//            result_i, fflags_i        - element value and exception flags
//            ctrl_reg_idxw_i, ctrl_warpid_i - element destination tag
//            out_valid_o/out_ready_i   - vector handshake to writeback
//            wb_data_o                 - element k at [(k+1)*W-1 -: W]
//            wb_fflags_o               - OR of all element flags
//            wb_reg_idxw_o, wb_warpid_o - element-0 tag
//            err_o                     - tag mismatch pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_result_collector
   import tc_result_collector_pkg::*;
#(
   parameter int unsigned NUM_ELEM  = C_NUM_ELEM_DEFAULT,
   parameter int unsigned EXPWIDTH  = 8,
   parameter int unsigned PRECISION = 24
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      in_valid_i,
   output logic                                      in_ready_o,
   input  logic [EXPWIDTH+PRECISION-1:0]             result_i,
   input  logic [C_FFLAGS_W-1:0]                     fflags_i,
   input  logic [C_REG_IDX_W-1:0]                    ctrl_reg_idxw_i,
   input  logic [`DEPTH_WARP-1:0]                    ctrl_warpid_i,
   output logic                                      out_valid_o,
   input  logic                                      out_ready_i,
   output logic [NUM_ELEM*(EXPWIDTH+PRECISION)-1:0]  wb_data_o,
   output logic [C_FFLAGS_W-1:0]                     wb_fflags_o,
   output logic [C_REG_IDX_W-1:0]                    wb_reg_idxw_o,
   output logic [`DEPTH_WARP-1:0]                    wb_warpid_o,
   output logic                                      err_o
);

   localparam int unsigned W     = EXPWIDTH + PRECISION;
   localparam int unsigned CNT_W = $clog2(NUM_ELEM);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_ELEM - 1);

   logic [CNT_W-1:0]          r_cnt;
   logic [(NUM_ELEM-1)*W-1:0] r_asm;          // slots 0 .. NUM_ELEM-2
   tc_tag_t                   r_tag;
   logic [C_FFLAGS_W-1:0]     r_acc_fflags;
   logic                      r_err;

   logic                      w_last;
   logic                      w_slot_can_load;
   logic                      w_accept;
   logic                      w_load;
   logic                      w_tag_mismatch;
   tc_tag_t                   w_in_tag;
   logic [NUM_ELEM*W-1:0]     w_pack;
   logic [C_FFLAGS_W-1:0]     w_pack_fflags;

   assign w_last   = (r_cnt == C_LAST);

   // Only the last element needs somewhere to go; earlier ones always fit in
   // the assembly register, so collection continues while the output stalls.
   assign in_ready_o = ~w_last | w_slot_can_load;
   assign w_accept   = in_valid_i & in_ready_o;
   assign w_load     = w_accept & w_last;

   assign w_in_tag       = '{reg_idxw: ctrl_reg_idxw_i, warpid: ctrl_warpid_i};
   assign w_tag_mismatch = (r_cnt != '0) && (w_in_tag != r_tag);

   // Last element goes straight from the input into the top slot.
   assign w_pack        = {result_i, r_asm};
   assign w_pack_fflags = r_acc_fflags | fflags_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_asm <= '0;
      end else if (w_accept && !w_last) begin
         for (int k = 0; k < int'(NUM_ELEM) - 1; k++) begin
            if (r_cnt == CNT_W'(k)) begin
               r_asm[k*W +: W] <= result_i;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_tag        <= '0;
         r_acc_fflags <= '0;
         r_err        <= 1'b0;
      end else begin
         r_err <= w_accept & w_tag_mismatch;
         if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (r_cnt == '0) begin
               // Element 0 starts a fresh vector: latch tag, restart flags.
               r_tag        <= w_in_tag;
               r_acc_fflags <= fflags_i;
            end else if (w_last) begin
               r_acc_fflags <= '0;
            end else begin
               r_acc_fflags <= r_acc_fflags | fflags_i;
            end
         end
      end
   end

   assign err_o = r_err;

   tc_wb_slot #(
      .DATA_W (NUM_ELEM * W)
   ) u_wb_slot (
      .clk         (clk),
      .rst         (rst),
      .load_i      (w_load),
      .data_i      (w_pack),
      .fflags_i    (w_pack_fflags),
      .reg_idxw_i  (r_tag.reg_idxw),
      .warpid_i    (r_tag.warpid),
      .can_load_o  (w_slot_can_load),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .data_o      (wb_data_o),
      .fflags_o    (wb_fflags_o),
      .reg_idxw_o  (wb_reg_idxw_o),
      .warpid_o    (wb_warpid_o)
   );

endmodule

`default_nettype wire
